// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM. Steps each instruction through fetch,
// decode, execute, memory and writeback, handshakes with a variable-latency
// memory, and counts retired instructions.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction memory; on ready latch IR and PC+4
// DECODE   | branch target precompute; dispatch on opcode
// EXEC_R   | ALU op from funct field
// WB_R     | write R-type result to rd
// EXEC_I   | ALU with sign-extended immediate (addi / slti)
// WB_I     | write immediate result to rt
// MEM_ADDR | effective address for lw / sw
// MEM_RD   | data read; wait for ready
// WB_MEM   | write loaded word to rt
// MEM_WR   | data write; wait for ready
// BRANCH   | compare rs/rt, conditional PC update
// JUMP     | PC <= jump target
// ERROR    | memory timeout; terminal until reset
module multi_cycle_ctrl #(
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 16,
    parameter int EN_JUMP = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [OP_W-1:0]  instr_op_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             IorD_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic             IRWrite_o,
    output logic             PCWrite_o,
    output logic             PCWriteCond_o,
    output logic [1:0]       PCSource_o,
    output logic             ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic [1:0]       ALUOp_o,
    output logic             RegDst_o,
    output logic             RegWrite_o,
    output logic             MemToReg_o,
    output logic             illegal_o,
    output logic             err_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_ERROR    = 4'd12
    } state_t;

    // Wide enough to hold TIMEOUT itself; the counter saturates at all-ones.
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_inc;
    logic              timed_out;
    logic              op_legal;

    // Saturating wait increment and timeout detect; a same-cycle ready wins.
    always_comb begin
        wait_inc  = (wait_cnt == '1) ? wait_cnt : wait_cnt + WAIT_W'(1);
        timed_out = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT)) && !mem_ready_i;
    end

    // Opcode legality, used for the illegal pulse in DECODE.
    always_comb begin
        op_legal = (instr_op_i == OP_RTYPE) || (instr_op_i == OP_ADDI) ||
                   (instr_op_i == OP_SLTI)  || (instr_op_i == OP_LW)   ||
                   (instr_op_i == OP_SW)    || (instr_op_i == OP_BEQ)  ||
                   ((EN_JUMP != 0) && (instr_op_i == OP_J));
    end

    // State sequencing, memory wait counter and retire counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            instr_cnt_o <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                S_FETCH: begin
                    if (mem_ready_i)    state <= S_DECODE;
                    else if (timed_out) state <= S_ERROR;
                    else                wait_cnt <= wait_inc;
                end
                S_DECODE: begin
                    if (instr_op_i == OP_RTYPE)
                        state <= S_EXEC_R;
                    else if ((instr_op_i == OP_ADDI) || (instr_op_i == OP_SLTI))
                        state <= S_EXEC_I;
                    else if ((instr_op_i == OP_LW) || (instr_op_i == OP_SW))
                        state <= S_MEM_ADDR;
                    else if (instr_op_i == OP_BEQ)
                        state <= S_BRANCH;
                    else if ((EN_JUMP != 0) && (instr_op_i == OP_J))
                        state <= S_JUMP;
                    else
                        state <= S_FETCH;
                end
                S_EXEC_R:   state <= S_WB_R;
                S_EXEC_I:   state <= S_WB_I;
                S_MEM_ADDR: state <= (instr_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (mem_ready_i)    state <= S_WB_MEM;
                    else if (timed_out) state <= S_ERROR;
                    else                wait_cnt <= wait_inc;
                end
                S_MEM_WR: begin
                    if (mem_ready_i) begin
                        state       <= S_FETCH;
                        instr_cnt_o <= instr_cnt_o + CNT_W'(1);
                    end else if (timed_out) begin
                        state <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
                    state       <= S_FETCH;
                    instr_cnt_o <= instr_cnt_o + CNT_W'(1);
                end
                S_ERROR: state <= S_ERROR;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Datapath controls decoded from state; everything held low during reset.
    always_comb begin
        mem_req_o     = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        PCSource_o    = 2'b00;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALUOp_o       = 2'b00;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        MemToReg_o    = 1'b0;
        illegal_o     = 1'b0;
        err_o         = 1'b0;
        if (rst_i) begin
            case (state)
                S_FETCH: begin
                    mem_req_o = 1'b1;
                    MemRead_o = 1'b1;
                    ALUSrcB_o = 2'b01;
                    IRWrite_o = mem_ready_i;
                    PCWrite_o = mem_ready_i;
                end
                S_DECODE: begin
                    ALUSrcB_o = 2'b11;
                    illegal_o = !op_legal;
                end
                S_EXEC_R: begin
                    ALUSrcA_o = 1'b1;
                    ALUOp_o   = 2'b10;
                end
                S_WB_R: begin
                    RegDst_o   = 1'b1;
                    RegWrite_o = 1'b1;
                end
                S_EXEC_I: begin
                    ALUSrcA_o = 1'b1;
                    ALUSrcB_o = 2'b10;
                    ALUOp_o   = (instr_op_i == OP_SLTI) ? 2'b11 : 2'b00;
                end
                S_WB_I: RegWrite_o = 1'b1;
                S_MEM_ADDR: begin
                    ALUSrcA_o = 1'b1;
                    ALUSrcB_o = 2'b10;
                end
                S_MEM_RD: begin
                    mem_req_o = 1'b1;
                    MemRead_o = 1'b1;
                    IorD_o    = 1'b1;
                end
                S_WB_MEM: begin
                    MemToReg_o = 1'b1;
                    RegWrite_o = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req_o  = 1'b1;
                    MemWrite_o = 1'b1;
                    IorD_o     = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA_o     = 1'b1;
                    ALUOp_o       = 2'b01;
                    PCWriteCond_o = 1'b1;
                    PCSource_o    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite_o  = 1'b1;
                    PCSource_o = 2'b10;
                end
                S_ERROR: err_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: hand sequences for per-state controls, a
// vector table of whole instructions, and randomized instructions against a
// latency/count model built from the instruction classes.
module tb_multi_cycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // DUT0: TIMEOUT=4, jumps enabled
    logic [5:0]  op0;
    logic        rdy0;
    logic        req0, iord0, mrd0, mwr0, irw0, pcw0, pcc0, asa0, rd0, rw0, m2r0, ill0, err0;
    logic [1:0]  pcs0, asb0, aop0;
    logic [3:0]  st0;
    logic [15:0] cnt0;
    logic [16:0] ctl0;

    // DUT1: timeout disabled, jumps disabled, 3-bit counter
    logic [5:0]  op1;
    logic        rdy1;
    logic        req1, iord1, mrd1, mwr1, irw1, pcw1, pcc1, asa1, rd1, rw1, m2r1, ill1, err1;
    logic [1:0]  pcs1, asb1, aop1;
    logic [3:0]  st1;
    logic [2:0]  cnt1;

    multi_cycle_ctrl #(.OP_W(6), .TIMEOUT(4), .EN_JUMP(1), .CNT_W(16)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .instr_op_i(op0), .mem_ready_i(rdy0),
        .mem_req_o(req0), .IorD_o(iord0), .MemRead_o(mrd0), .MemWrite_o(mwr0),
        .IRWrite_o(irw0), .PCWrite_o(pcw0), .PCWriteCond_o(pcc0), .PCSource_o(pcs0),
        .ALUSrcA_o(asa0), .ALUSrcB_o(asb0), .ALUOp_o(aop0), .RegDst_o(rd0),
        .RegWrite_o(rw0), .MemToReg_o(m2r0), .illegal_o(ill0), .err_o(err0),
        .state_o(st0), .instr_cnt_o(cnt0));

    multi_cycle_ctrl #(.OP_W(6), .TIMEOUT(0), .EN_JUMP(0), .CNT_W(3)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .instr_op_i(op1), .mem_ready_i(rdy1),
        .mem_req_o(req1), .IorD_o(iord1), .MemRead_o(mrd1), .MemWrite_o(mwr1),
        .IRWrite_o(irw1), .PCWrite_o(pcw1), .PCWriteCond_o(pcc1), .PCSource_o(pcs1),
        .ALUSrcA_o(asa1), .ALUSrcB_o(asb1), .ALUOp_o(aop1), .RegDst_o(rd1),
        .RegWrite_o(rw1), .MemToReg_o(m2r1), .illegal_o(ill1), .err_o(err1),
        .state_o(st1), .instr_cnt_o(cnt1));

    assign ctl0 = {req0, iord0, mrd0, mwr0, irw0, pcw0, pcc0, pcs0, asa0, asb0, aop0, rd0, rw0, m2r0};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] mk(input logic mreq, iord, mrd, mwr, irw, pcw, pcc,
                                       input logic [1:0] pcs, input logic asa,
                                       input logic [1:0] asb, aop,
                                       input logic rd, rw, m2r);
        return {mreq, iord, mrd, mwr, irw, pcw, pcc, pcs, asa, asb, aop, rd, rw, m2r};
    endfunction

    // Reference model: instruction classes and their cycle costs.
    function automatic bit is_legal(input logic [5:0] op, input bit en_j);
        return op == OP_R || op == OP_ADDI || op == OP_SLTI || op == OP_LW ||
               op == OP_SW || op == OP_BEQ || (en_j && op == OP_J);
    endfunction

    function automatic bit is_mem(input logic [5:0] op);
        return op == OP_LW || op == OP_SW;
    endfunction

    function automatic int exp_len(input logic [5:0] op, input int fw, input int mw);
        int base;
        if (op == OP_LW) base = 5;
        else if (op == OP_R || op == OP_ADDI || op == OP_SLTI || op == OP_SW) base = 4;
        else if (op == OP_BEQ || op == OP_J) base = 3;
        else base = 2;
        return base + fw + (is_mem(op) ? mw : 0);
    endfunction

    // One cycle of hand stimulus: drive ready at the falling edge, check controls.
    task automatic step(input string nm, input logic rdy, input logic [16:0] exp);
        @(negedge clk);
        rdy0 = rdy;
        #1;
        chk(nm, 32'(ctl0), 32'(exp));
    endtask

    // Run one instruction on DUT0 from FETCH: fw fetch wait cycles, mw data
    // wait cycles. Returns cycles until next FETCH entry and observed events.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             output int cycles, output int ills, output int dreq,
                             output int m2r_seen);
        int  fcnt = 0;
        int  mcnt = 0;
        bit  done = 0;
        cycles = 0; ills = 0; dreq = 0; m2r_seen = 0;
        op0 = op;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (req0 && !iord0) begin
                rdy0 = (fcnt == fw);
                fcnt++;
            end else if (req0) begin
                rdy0 = (mcnt == mw);
                mcnt++;
                dreq++;
            end else begin
                rdy0 = 1'($urandom_range(0, 1));
            end
            #1;
            if (ill0) ills++;
            if (m2r0 && rw0 && !rd0) m2r_seen = 1;
            cycles++;
            @(posedge clk);
            #1;
            if (fcnt > fw && req0 && mrd0 && !iord0) done = 1;
        end
        chk("instr_done", 32'(done), 32'd1);
    endtask

    typedef struct {
        logic [5:0] op;
        int fw, mw, cyc, ret, ill, dreq, m2r;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] model_cnt;
        int cyc, ills, dreq, m2r;
        logic [5:0] rop;

        tbl[0]  = '{OP_R,      0, 0,  4, 1, 0, 0, 0};
        tbl[1]  = '{OP_ADDI,   1, 0,  5, 1, 0, 0, 0};
        tbl[2]  = '{OP_SLTI,   2, 0,  6, 1, 0, 0, 0};
        tbl[3]  = '{OP_LW,     0, 3,  8, 1, 0, 4, 1};
        tbl[4]  = '{OP_SW,     0, 0,  4, 1, 0, 1, 0};
        tbl[5]  = '{OP_SW,     2, 2,  8, 1, 0, 3, 0};
        tbl[6]  = '{OP_BEQ,    0, 0,  3, 1, 0, 0, 0};
        tbl[7]  = '{OP_J,      0, 0,  3, 1, 0, 0, 0};
        tbl[8]  = '{6'b111111, 0, 0,  2, 0, 1, 0, 0};
        tbl[9]  = '{OP_LW,     4, 4, 13, 1, 0, 5, 1};
        tbl[10] = '{6'b000001, 1, 0,  3, 0, 1, 0, 0};

        rst_n = 1'b0;
        op0 = OP_R; rdy0 = 1'b0;
        op1 = OP_R; rdy1 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctl", 32'(ctl0), 32'd0);
        chk("rst_ill_err", 32'({ill0, err0}), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("fetch_after_rst", 32'(ctl0), 32'(mk(1,0,1,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0)));

        // R-type, ready immediately
        step("r_fetch",  1, mk(1,0,1,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0));
        step("r_decode", 1, mk(0,0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0));
        step("r_exec",   1, mk(0,0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0));
        step("r_wb",     1, mk(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,1,0));
        chk("r_cnt_before", 32'(cnt0), 32'd0);
        @(posedge clk);
        #1;
        chk("r_cnt_after", 32'(cnt0), 32'd1);
        model_cnt = 16'd1;

        for (int i = 0; i < 11; i++) begin
            run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, cyc, ills, dreq, m2r);
            model_cnt += 16'(tbl[i].ret);
            chk($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
            chk($sformatf("tbl%0d_illegal", i), 32'(ills), 32'(tbl[i].ill));
            chk($sformatf("tbl%0d_dreq", i), 32'(dreq), 32'(tbl[i].dreq));
            chk($sformatf("tbl%0d_m2r", i), 32'(m2r), 32'(tbl[i].m2r));
            chk($sformatf("tbl%0d_cnt", i), 32'(cnt0), 32'(model_cnt));
        end

        // slti: ALUOp 11 in EXEC_I
        op0 = OP_SLTI;
        step("slti_fetch",  1, mk(1,0,1,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0));
        step("slti_decode", 1, mk(0,0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0));
        step("slti_exec",   1, mk(0,0,0,0,0,0,0,2'b00,1,2'b10,2'b11,0,0,0));
        step("slti_wb",     1, mk(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,0));
        // j: PCWrite with jump-target source
        op0 = OP_J;
        step("j_fetch",  1, mk(1,0,1,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0));
        step("j_decode", 1, mk(0,0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0));
        step("j_jump",   1, mk(0,0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0));
        model_cnt += 16'd2;
        @(posedge clk);
        #1;
        chk("slti_j_cnt", 32'(cnt0), 32'(model_cnt));

        // Randomized instructions against the model
        for (int i = 0; i < 30; i++) begin
            int fw, mw;
            case ($urandom_range(0, 7))
                0: rop = OP_R;
                1: rop = OP_ADDI;
                2: rop = OP_SLTI;
                3: rop = OP_LW;
                4: rop = OP_SW;
                5: rop = OP_BEQ;
                6: rop = OP_J;
                default: begin
                    rop = 6'($urandom);
                    while (is_legal(rop, 1'b1)) rop = 6'($urandom);
                end
            endcase
            fw = $urandom_range(0, 4);
            mw = $urandom_range(0, 4);
            run_instr(rop, fw, mw, cyc, ills, dreq, m2r);
            if (is_legal(rop, 1'b1)) model_cnt += 16'd1;
            chk($sformatf("rnd%0d_op%0h_cycles", i, rop), 32'(cyc), 32'(exp_len(rop, fw, mw)));
            chk($sformatf("rnd%0d_illegal", i), 32'(ills), 32'(is_legal(rop, 1'b1) ? 0 : 1));
            chk($sformatf("rnd%0d_dreq", i), 32'(dreq), 32'(is_mem(rop) ? mw + 1 : 0));
            chk($sformatf("rnd%0d_cnt", i), 32'(cnt0), 32'(model_cnt));
        end

        // Reset in the middle of a store: controls drop with no clock edge
        op0 = OP_SW;
        step("sw_fetch",  1, mk(1,0,1,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0));
        step("sw_decode", 1, mk(0,0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0));
        step("sw_addr",   1, mk(0,0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0));
        step("sw_memwr",  0, mk(1,1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0));
        chk("cnt_pre_rst", 32'(cnt0), 32'(model_cnt));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_memwrite", 32'(mwr0), 32'd0);
        chk("midrst_ctl", 32'(ctl0), 32'd0);
        chk("midrst_cnt", 32'(cnt0), 32'd0);
        @(negedge clk);
        rdy0 = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("midrst_fetch", 32'(ctl0), 32'(mk(1,0,1,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0)));

        // Timeout: five wait cycles in FETCH with TIMEOUT=4 -> ERROR
        for (int i = 0; i < 4; i++)
            step($sformatf("to_wait%0d", i), 0, mk(1,0,1,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0));
        chk("to_no_err_yet", 32'(err0), 32'd0);
        @(posedge clk);
        #1;
        chk("to_err", 32'(err0), 32'd1);
        chk("to_err_ctl", 32'(ctl0), 32'd0);
        rdy0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("to_err_sticky", 32'(err0), 32'd1);
        chk("to_err_ctl_ready", 32'(ctl0), 32'd0);
        chk("to_err_cnt", 32'(cnt0), 32'd0);

        // DUT1: long stall without timeout, j illegal, counter wrap
        repeat (40) @(posedge clk);
        #1;
        chk("d1_no_timeout", 32'({err1, req1, mrd1}), 32'b011);
        op1 = OP_J;
        @(negedge clk);
        rdy1 = 1'b1;
        #1;
        chk("d1_fetch_irw", 32'(irw1), 32'd1);
        @(negedge clk);
        #1;
        chk("d1_j_illegal", 32'(ill1), 32'd1);
        @(posedge clk);
        #1;
        op1 = OP_BEQ;
        chk("d1_back_fetch", 32'({ill1, req1, iord1}), 32'b010);
        chk("d1_cnt_unchanged", 32'(cnt1), 32'd0);
        repeat (27) @(posedge clk);
        #1;
        chk("d1_cnt_wrap", 32'(cnt1), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
